// File: rtl/count_sequencer_if.sv
// Control/status bundle between a host and count_sequencer.
// The presc field exists only when COUNT_SEQ_PRESCALE_EN is defined.
interface count_sequencer_if #(
  parameter int unsigned WIDTH = 4
`ifdef COUNT_SEQ_PRESCALE_EN
  , parameter int unsigned PRESCALE_W = 4
`endif
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode_reload;
  logic [WIDTH-1:0] limit;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc;
`endif
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;

`ifdef COUNT_SEQ_PRESCALE_EN
  modport master (
    output start, stop, pause, mode_reload, limit, presc,
    input  Q, busy, tc, done
  );
  modport slave (
    input  start, stop, pause, mode_reload, limit, presc,
    output Q, busy, tc, done
  );
`else
  modport master (
    output start, stop, pause, mode_reload, limit,
    input  Q, busy, tc, done
  );
  modport slave (
    input  start, stop, pause, mode_reload, limit,
    output Q, busy, tc, done
  );
`endif
endinterface

// File: rtl/count_sequencer.sv
// Start/stop/pause sequencer driving a WIDTH-bit up-counter in one-shot or auto-reload mode.
// Define COUNT_SEQ_PRESCALE_EN to add a programmable tick prescaler.
module count_sequencer #(
  parameter int unsigned WIDTH = 4
`ifdef COUNT_SEQ_PRESCALE_EN
  , parameter int unsigned PRESCALE_W = 4
`endif
) (
  input  logic             CLK,
  input  logic             Reset,
  count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             tick;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == presc_q);

  // Prescaler only advances on cycles where the counter itself would be allowed to count.
  always_comb begin
    pcnt_d  = pcnt_q;
    presc_d = presc_q;
    unique case (state_q)
      StIdle: begin
        pcnt_d = '0;
        if (bus.start && !bus.stop) presc_d = bus.presc;
      end
      StRun, StHold: begin
        if (bus.stop) begin
          pcnt_d = '0;
        end else if (!bus.pause) begin
          pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end
      end
      default: pcnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        q_d = '0;
        if (bus.start && !bus.stop) begin
          limit_d = bus.limit;
          mode_d  = bus.mode_reload;
          state_d = (bus.limit == '0) ? StDone : StRun;
        end
      end
      // Releasing pause counts on that same edge, so a pause of N cycles delays by exactly N.
      StRun, StHold: begin
        if (bus.stop) begin
          state_d = StIdle;
          q_d     = '0;
        end else if (bus.pause) begin
          state_d = StHold;
        end else begin
          state_d = StRun;
          if (tick) begin
            if (q_q == limit_q) begin
              if (mode_q) q_d = '0;
              else        state_d = StDone;
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        q_d     = '0;
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.busy = (state_q == StRun) || (state_q == StHold);
  assign bus.tc   = bus.busy && (q_q == limit_q);
  assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; expected {Q,busy,tc,done} are hand-derived per cycle.
module tb_count_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  count_sequencer_if #(.WIDTH(4)) bus ();

  count_sequencer #(.WIDTH(4)) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] lim, input logic reload);
    bus.limit       = lim;
    bus.mode_reload = reload;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({bus.Q, bus.busy, bus.tc, bus.done} !== 7'b0000_000) begin
      failures++;
      $display("FAIL reset: got Q=%0d busy=%b tc=%b done=%b, want 0/0/0/0",
               bus.Q, bus.busy, bus.tc, bus.done);
    end
  endtask

  task automatic test_oneshot();
    int busy_cycles = 0;
    start_run(4'd5, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'(k), 1'b1, (k == 5), 1'b0}) begin
        failures++;
        $display("FAIL oneshot k=%0d: got Q=%0d busy=%b tc=%b done=%b, want Q=%0d busy=1 tc=%b done=0",
                 k, bus.Q, bus.busy, bus.tc, bus.done, k, (k == 5));
      end
      if (bus.busy) busy_cycles++;
      step();
    end
    checks++;
    if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'd5, 3'b001}) begin
      failures++;
      $display("FAIL oneshot_done: got Q=%0d busy=%b tc=%b done=%b, want Q=5 busy=0 tc=0 done=1",
               bus.Q, bus.busy, bus.tc, bus.done);
    end
    step();
    checks++;
    if ({bus.Q, bus.busy, bus.tc, bus.done} !== 7'b0000_000) begin
      failures++;
      $display("FAIL oneshot_idle: got Q=%0d busy=%b tc=%b done=%b, want 0/0/0/0",
               bus.Q, bus.busy, bus.tc, bus.done);
    end
    checks++;
    if (busy_cycles !== 6) begin
      failures++;
      $display("FAIL oneshot_busy_len: got %0d, want 6", busy_cycles);
    end
  endtask

  task automatic test_reload();
    int tc_count = 0;
    start_run(4'd3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'(i % 4), 1'b1, ((i % 4) == 3), 1'b0}) begin
        failures++;
        $display("FAIL reload i=%0d: got Q=%0d busy=%b tc=%b done=%b, want Q=%0d busy=1 tc=%b done=0",
                 i, bus.Q, bus.busy, bus.tc, bus.done, i % 4, ((i % 4) == 3));
      end
      if (bus.tc) tc_count++;
      step();
    end
    checks++;
    if (tc_count !== 3) begin
      failures++;
      $display("FAIL reload_tc_count: got %0d, want 3", tc_count);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_pause();
    start_run(4'd6, 1'b0);
    step();
    step();
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'd2, 3'b100}) begin
        failures++;
        $display("FAIL pause_hold i=%0d: got Q=%0d busy=%b tc=%b done=%b, want Q=2 busy=1 tc=0 done=0",
                 i, bus.Q, bus.busy, bus.tc, bus.done);
      end
    end
    bus.pause = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      step();
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'(k), 1'b1, (k == 6), 1'b0}) begin
        failures++;
        $display("FAIL pause_resume k=%0d: got Q=%0d busy=%b tc=%b done=%b, want Q=%0d busy=1",
                 k, bus.Q, bus.busy, bus.tc, bus.done, k);
      end
    end
    step();
    checks++;
    if ({bus.Q, bus.busy, bus.done} !== {4'd6, 2'b01}) begin
      failures++;
      $display("FAIL pause_done: got Q=%0d busy=%b done=%b, want Q=6 busy=0 done=1",
               bus.Q, bus.busy, bus.done);
    end
    step();
  endtask

  task automatic test_stop();
    start_run(4'd9, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.Q !== 4'd4) begin
      failures++;
      $display("FAIL stop_pre: got Q=%0d, want 4", bus.Q);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== 7'b0000_000) begin
        failures++;
        $display("FAIL stop_abort i=%0d: got Q=%0d busy=%b tc=%b done=%b, want 0/0/0/0",
                 i, bus.Q, bus.busy, bus.tc, bus.done);
      end
      step();
    end
    bus.limit = 4'd9;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.done} !== 6'b0000_00) begin
        failures++;
        $display("FAIL start_stop_idle i=%0d: got Q=%0d busy=%b done=%b, want 0/0/0",
                 i, bus.Q, bus.busy, bus.done);
      end
      step();
    end
  endtask

  task automatic test_limit_edges();
    start_run(4'd0, 1'b0);
    checks++;
    if ({bus.Q, bus.busy, bus.tc, bus.done} !== 7'b0000_001) begin
      failures++;
      $display("FAIL limit0_done: got Q=%0d busy=%b tc=%b done=%b, want Q=0 busy=0 tc=0 done=1",
               bus.Q, bus.busy, bus.tc, bus.done);
    end
    step();
    checks++;
    if ({bus.Q, bus.busy, bus.done} !== 6'b0000_00) begin
      failures++;
      $display("FAIL limit0_idle: got Q=%0d busy=%b done=%b, want 0/0/0",
               bus.Q, bus.busy, bus.done);
    end
    start_run(4'd15, 1'b0);
    for (int k = 0; k <= 15; k++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== {4'(k), 1'b1, (k == 15), 1'b0}) begin
        failures++;
        $display("FAIL limit15 k=%0d: got Q=%0d busy=%b tc=%b done=%b, want Q=%0d busy=1 tc=%b",
                 k, bus.Q, bus.busy, bus.tc, bus.done, k, (k == 15));
      end
      step();
    end
    checks++;
    if ({bus.Q, bus.busy, bus.done} !== {4'd15, 2'b01}) begin
      failures++;
      $display("FAIL limit15_done: got Q=%0d busy=%b done=%b, want Q=15 busy=0 done=1",
               bus.Q, bus.busy, bus.done);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    start_run(4'd10, 1'b0);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.Q !== 4'd6) begin
      failures++;
      $display("FAIL midrun_pre: got Q=%0d, want 6", bus.Q);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.tc, bus.done} !== 7'b0000_000) begin
        failures++;
        $display("FAIL midrun_reset i=%0d: got Q=%0d busy=%b tc=%b done=%b, want 0/0/0/0",
                 i, bus.Q, bus.busy, bus.tc, bus.done);
      end
      step();
    end
  endtask

`ifdef COUNT_SEQ_PRESCALE_EN
  task automatic test_prescale();
    bus.presc = 4'd2;
    start_run(4'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({bus.Q, bus.busy, bus.done} !== {4'(i / 3), 2'b10}) begin
        failures++;
        $display("FAIL prescale i=%0d: got Q=%0d busy=%b done=%b, want Q=%0d busy=1 done=0",
                 i, bus.Q, bus.busy, bus.done, i / 3);
      end
      step();
    end
    checks++;
    if ({bus.Q, bus.done} !== {4'd2, 1'b1}) begin
      failures++;
      $display("FAIL prescale_done: got Q=%0d done=%b, want Q=2 done=1", bus.Q, bus.done);
    end
    step();
    bus.presc = 4'd0;
  endtask
`endif

  initial begin
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.pause       = 1'b0;
    bus.mode_reload = 1'b0;
    bus.limit       = '0;
`ifdef COUNT_SEQ_PRESCALE_EN
    bus.presc       = '0;
`endif
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_stop();
    test_limit_edges();
    test_reset_midrun();
`ifdef COUNT_SEQ_PRESCALE_EN
    test_prescale();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
